// File: rtl/inst_mem_loader.sv
// Boot loader: turns a framed byte stream into sequential 32-bit instruction-memory writes,
// checks a trailing XOR checksum and releases the CPU from reset only after a clean load.
module inst_mem_loader #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              s_valid_i,
    input  logic [7:0]        s_data_i,
    output logic              s_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              cpu_reset_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W:0]   words_loaded_o
);

    localparam logic [16:0] MaxWords = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        StIdle, StHdrLo, StHdrHi, StData, StChk, StDone, StError
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
    logic [15:0]         count_q, count_d;
    logic [7:0]          chk_q, chk_d;
    logic [23:0]         word_q, word_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]     wl_q, wl_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                accept;
    logic                last_word;

    assign s_ready_o = (state_q == StHdrLo) || (state_q == StHdrHi) ||
                       (state_q == StData)  || (state_q == StChk);
    assign accept    = s_valid_i && s_ready_o;
    assign last_word = ({{(16 - ADDR_W){1'b0}}, word_cnt_q} == (count_q - 16'd1));

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        word_cnt_d  = word_cnt_q;
        count_d     = count_q;
        chk_d       = chk_q;
        word_d      = word_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wl_d        = wl_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start_i) begin
                    state_d    = StHdrLo;
                    wl_d       = '0;
                    chk_d      = '0;
                    byte_idx_d = '0;
                    word_cnt_d = '0;
                end
            end
            StHdrLo: begin
                if (accept) begin
                    count_d[7:0] = s_data_i;
                    state_d      = StHdrHi;
                end
            end
            StHdrHi: begin
                if (accept) begin
                    count_d = {s_data_i, count_q[7:0]};
                    if (count_d == 16'd0) begin
                        state_d = StChk;
                    end else if ({1'b0, count_d} > MaxWords) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    chk_d = chk_q ^ s_data_i;
                    if (byte_idx_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_cnt_q;
                        mem_wdata_d = {s_data_i, word_q};
                        wl_d        = wl_q + (ADDR_W + 1)'(1);
                        word_cnt_d  = word_cnt_q + ADDR_W'(1);
                        byte_idx_d  = 2'd0;
                        if (last_word) begin
                            state_d = StChk;
                        end
                    end else begin
                        case (byte_idx_q)
                            2'd0:    word_d[7:0]   = s_data_i;
                            2'd1:    word_d[15:8]  = s_data_i;
                            default: word_d[23:16] = s_data_i;
                        endcase
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            StChk: begin
                if (accept) begin
                    state_d = (s_data_i == chk_q) ? StDone : StError;
                end
            end
            default: state_d = StIdle;
        endcase

        // Status outputs are registered copies of the state being entered.
        busy_d      = (state_d == StHdrLo) || (state_d == StHdrHi) ||
                      (state_d == StData)  || (state_d == StChk);
        done_d      = (state_d == StDone);
        error_d     = (state_d == StError);
        cpu_reset_d = (state_d != StDone);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            byte_idx_q  <= '0;
            word_cnt_q  <= '0;
            count_q     <= '0;
            chk_q       <= '0;
            word_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wl_q        <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            word_cnt_q  <= word_cnt_d;
            count_q     <= count_d;
            chk_q       <= chk_d;
            word_q      <= word_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wl_q        <= wl_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign words_loaded_o = wl_q;
    assign cpu_reset_o    = cpu_reset_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: cycle-by-cycle vector table plus hand-written
// sequences for gapped streams, mid-load reset and start-pulse handling.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [6:0]  words_loaded;

    int n_cmp = 0;
    int n_err = 0;

    logic [5:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        ready;
        logic        we;
        logic        busy;
        logic        done;
        logic        err;
        logic        cpu;
        logic [5:0]  addr;
        logic [6:0]  wl;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs[$];

    inst_mem_loader #(.ADDR_W(6)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .s_valid_i     (s_valid),
        .s_data_i      (s_data),
        .s_ready_o     (s_ready),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .cpu_reset_o   (cpu_reset),
        .busy_o        (busy),
        .done_o        (done),
        .error_o       (error),
        .words_loaded_o(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        s_valid = 1'b1;
        s_data  = b;
        tick();
        s_valid = 1'b0;
        s_data  = 8'h00;
    endtask

    function automatic void add(input logic st, input logic v, input logic [7:0] d,
                                input logic rdy, input logic we, input logic bz,
                                input logic dn, input logic er, input logic cr,
                                input logic [5:0] a, input logic [6:0] wl,
                                input logic [31:0] wd);
        vecs.push_back('{st, v, d, rdy, we, bz, dn, er, cr, a, wl, wd});
    endfunction

    function automatic logic [63:0] pack_out();
        return {14'd0, mem_we, busy, done, error, cpu_reset, mem_addr, words_loaded, mem_wdata};
    endfunction

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic check_normal_writes(input string tag);
        check({tag, "_nwr"}, 64'(wr_addr.size()), 64'd2);
        if (wr_addr.size() == 2) begin
            check({tag, "_a0"}, 64'(wr_addr[0]), 64'd0);
            check({tag, "_d0"}, 64'(wr_data[0]), 64'h00A00513);
            check({tag, "_a1"}, 64'(wr_addr[1]), 64'd1);
            check({tag, "_d1"}, 64'(wr_data[1]), 64'h00500593);
        end
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_cpu"}, {63'd0, cpu_reset}, 64'd0);
        check({tag, "_wl"}, 64'(words_loaded), 64'd2);
    endtask

    localparam logic [31:0] W0 = 32'h00A00513;
    localparam logic [31:0] W1 = 32'h00500593;

    initial begin
        logic [7:0] frame[11];
        frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00, 8'h70};

        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        #12;
        check("rst_outputs", pack_out(), {14'd0, 5'b00001, 6'd0, 7'd0, 32'd0});
        check("rst_ready", {63'd0, s_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Normal load from IDLE.
        add(1, 0, 8'h00, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 8'h02, 1, 0, 1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 8'h00, 1, 0, 1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 8'h13, 1, 0, 1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 8'h05, 1, 0, 1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 8'hA0, 1, 0, 1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 8'h00, 1, 1, 1, 0, 0, 1, 0, 1, W0);
        add(0, 1, 8'h93, 1, 0, 1, 0, 0, 1, 0, 1, W0);
        add(0, 1, 8'h05, 1, 0, 1, 0, 0, 1, 0, 1, W0);
        add(0, 1, 8'h50, 1, 0, 1, 0, 0, 1, 0, 1, W0);
        add(0, 1, 8'h00, 1, 1, 1, 0, 0, 1, 1, 2, W1);
        add(0, 1, 8'h70, 1, 0, 0, 1, 0, 0, 1, 2, W1);
        add(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 2, W1);
        // Bad checksum, restarted from DONE.
        add(1, 0, 8'h00, 0, 0, 1, 0, 0, 1, 1, 0, W1);
        add(0, 1, 8'h02, 1, 0, 1, 0, 0, 1, 1, 0, W1);
        add(0, 1, 8'h00, 1, 0, 1, 0, 0, 1, 1, 0, W1);
        add(0, 1, 8'h13, 1, 0, 1, 0, 0, 1, 1, 0, W1);
        add(0, 1, 8'h05, 1, 0, 1, 0, 0, 1, 1, 0, W1);
        add(0, 1, 8'hA0, 1, 0, 1, 0, 0, 1, 1, 0, W1);
        add(0, 1, 8'h00, 1, 1, 1, 0, 0, 1, 0, 1, W0);
        add(0, 1, 8'h93, 1, 0, 1, 0, 0, 1, 0, 1, W0);
        add(0, 1, 8'h05, 1, 0, 1, 0, 0, 1, 0, 1, W0);
        add(0, 1, 8'h50, 1, 0, 1, 0, 0, 1, 0, 1, W0);
        add(0, 1, 8'h00, 1, 1, 1, 0, 0, 1, 1, 2, W1);
        add(0, 1, 8'h71, 1, 0, 0, 0, 1, 1, 1, 2, W1);
        add(0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 1, 2, W1);
        // Empty frame, restarted from ERROR.
        add(1, 0, 8'h00, 0, 0, 1, 0, 0, 1, 1, 0, W1);
        add(0, 1, 8'h00, 1, 0, 1, 0, 0, 1, 1, 0, W1);
        add(0, 1, 8'h00, 1, 0, 1, 0, 0, 1, 1, 0, W1);
        add(0, 1, 8'h00, 1, 0, 0, 1, 0, 0, 1, 0, W1);
        add(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 0, W1);
        // Oversize count N=65.
        add(1, 0, 8'h00, 0, 0, 1, 0, 0, 1, 1, 0, W1);
        add(0, 1, 8'h41, 1, 0, 1, 0, 0, 1, 1, 0, W1);
        add(0, 1, 8'h00, 1, 0, 0, 0, 1, 1, 1, 0, W1);
        add(0, 1, 8'h00, 0, 0, 0, 0, 1, 1, 1, 0, W1);

        for (int i = 0; i < vecs.size(); i++) begin
            start   = vecs[i].start;
            s_valid = vecs[i].valid;
            s_data  = vecs[i].data;
            check($sformatf("vec%0d_ready", i), {63'd0, s_ready}, {63'd0, vecs[i].ready});
            tick();
            check($sformatf("vec%0d_out", i), pack_out(),
                  {14'd0, vecs[i].we, vecs[i].busy, vecs[i].done, vecs[i].err, vecs[i].cpu,
                   vecs[i].addr, vecs[i].wl, vecs[i].wdata});
        end
        start   = 1'b0;
        s_valid = 1'b0;

        // Gapped stream.
        clear_writes();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) send(frame[i], int'($urandom_range(0, 3)));
        tick();
        check_normal_writes("gap");

        // Reset before the first word completes: nothing must be written.
        clear_writes();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) send(frame[i], int'($urandom_range(0, 3)));
        s_valid = 1'b1;
        s_data  = frame[5];
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_outputs", pack_out(), {14'd0, 5'b00001, 6'd0, 7'd0, 32'd0});
        check("mrst_ready", {63'd0, s_ready}, 64'd0);
        tick();
        s_valid = 1'b0;
        rst_n   = 1'b1;
        tick();
        check("mrst_nwr", 64'(wr_addr.size()), 64'd0);
        check("mrst_idle", pack_out(), {14'd0, 5'b00001, 6'd0, 7'd0, 32'd0});

        // Start pulse during DATA is ignored.
        clear_writes();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) send(frame[i], 0);
        start = 1'b1;
        send(frame[4], 0);
        start = 1'b0;
        for (int i = 5; i < 11; i++) send(frame[i], 1);
        tick();
        check_normal_writes("sdata");

        // Start in DONE restarts on the next cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sdone_cpu", {63'd0, cpu_reset}, 64'd1);
        check("sdone_busy", {63'd0, busy}, 64'd1);
        check("sdone_done", {63'd0, done}, 64'd0);
        check("sdone_ready", {63'd0, s_ready}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Boot-time writer for the instruction memory that the pipeline's fetch stage reads.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes the words sequentially into instruction memory from word 0 and verifies a trailing XOR checksum.
- Holds the CPU in reset until a load completes cleanly.

Parameters:
- ADDR_W, 6, instruction-memory word-address width; depth = 2**ADDR_W words (64 by default).

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-low reset.
- start, input, 1, one-cycle pulse that begins a load; sampled only in IDLE, DONE and ERROR.
- s_valid, input, 1, byte-stream valid.
- s_data, input, 8, byte-stream data.
- s_ready, output, 1, byte accepted on a cycle where s_valid && s_ready.
- mem_we, output, 1, instruction-memory write strobe, one cycle per word.
- mem_addr, output, ADDR_W, word address for the write.
- mem_wdata, output, 32, word written.
- cpu_reset, output, 1, active-high reset to the pipeline.
- busy, output, 1, load in progress.
- done, output, 1, last load succeeded.
- error, output, 1, last load failed.
- words_loaded, output, ADDR_W+1, words written in the current or last load.

Behaviour:
- Reset (reset low, asynchronous):
  - State = IDLE.
  - cpu_reset=1; s_ready, mem_we, busy, done, error = 0.
  - mem_addr, mem_wdata, words_loaded = 0.
  - Internal byte index, word counter, count and checksum registers cleared.
- Frame format: count_lo, count_hi (16-bit word count N), then 4*N payload bytes, then 1 checksum byte.
  - Checksum = XOR of all payload bytes only; the header is excluded.
- FSM states: IDLE, HDR_LO, HDR_HI, DATA, CHK, DONE, ERROR. All outputs are registered except s_ready.
- s_ready = 1 exactly in HDR_LO, HDR_HI, DATA and CHK (decoded from state). There is no stall during memory writes.
- busy = 1 in HDR_LO..CHK. done = 1 only in DONE. error = 1 only in ERROR.
- cpu_reset = 0 only in DONE.
- IDLE / DONE / ERROR, on start:
  - Go to HDR_LO.
  - Clear words_loaded, checksum, byte index and word counter.
  - done/error drop and cpu_reset = 1 from the next cycle.
- start in any other state is ignored.
- HDR_LO: on accept, latch the low byte and go to HDR_HI.
- HDR_HI: on accept, form N = {hi, lo}, then:
  - N == 0 goes to CHK.
  - N > 2**ADDR_W goes to ERROR.
  - Otherwise go to DATA.
- DATA:
  - Byte k of a word (k = 0..3) fills bits [8k+7:8k] (little-endian).
  - Every accepted payload byte is XORed into the checksum.
  - On accepting the 4th byte, in the next cycle: mem_we=1, mem_addr=word counter, mem_wdata=the assembled word, words_loaded+1. mem_we is high for exactly one cycle.
  - The word counter increments; mem_addr holds its value after the strobe.
  - After the 4th byte of word N-1, go to CHK. The last write strobe occurs in the first CHK cycle.
- CHK: on accept, a byte equal to the running checksum goes to DONE; otherwise go to ERROR.
  - Words already written are not rolled back; the CPU stays in reset on error.
- Wrap-around: the word counter never exceeds N-1 ≤ 2**ADDR_W-1, so the address does not wrap.
- Cycles with s_valid=0 stall the FSM with no side effects. Back-to-back bytes are accepted at one per cycle.
- Reset asserted mid-load: immediate return to IDLE with reset values.
  - Memory contents already written are left as is.
  - No partial word is written.

Test Plan:
- Normal load: start; stream 02 00 13 05 A0 00 93 05 50 00 70 → mem_we at addr 0 with 0x00A00513, then addr 1 with 0x00500593; done=1, cpu_reset=0, words_loaded=2, error=0.
- Bad checksum: same frame with final byte 71 → two writes occur, then error=1, done=0, cpu_reset=1, s_ready=0.
- Empty frame: 00 00 00 → no mem_we, done=1, words_loaded=0, cpu_reset=0.
- Oversize count: 41 00 (N=65, ADDR_W=6) → ERROR the cycle after the second byte, no mem_we, s_ready=0.
- Gapped stream and mid-load reset:
  - Normal-load frame with 0–3 random idle cycles between bytes → identical writes and done.
  - Repeat, driving reset low after the 6th byte → IDLE, cpu_reset=1, words_loaded=0, mem_we never asserted.
- start handling: a start pulse during DATA is ignored (load completes normally); a start pulse in DONE restarts, cpu_reset=1 next cycle, busy=1, done=0.
